// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational, no backpressure.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial a+b+cin, LSB first, through one full_adder; result valid WIDTH cycles after accept.
// Result held while out_valid && !out_ready; in_ready only in IDLE. ovf exists with SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_t        state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             fa_sum;
  logic             fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Partial sum with the current bit entering at the MSB; bit 0 of the
  // shifted view is dropped, so the register only keeps WIDTH-1 bits.
  assign sum_next = {fa_sum, sum_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sr <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_sr <= sum_next[WIDTH-1:1];
          carry  <= fa_cout;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            sum_q  <= sum_next;
            cout_q <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on this edge
            ovf_q  <= carry ^ fa_cout;
`endif
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8); checks ovf when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, wait for the result, check it, then complete the
  // output handshake unless hold is set (caller then owns out_ready).
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] es, input logic ec,
                        input logic eo, input logic hold);
    int lat;
    chk({tag, ".in_ready_pre"}, 64'(in_ready), 64'd1);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(W));
    chk({tag, ".sum"}, 64'(sum), 64'(es));
    chk({tag, ".cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo === 1'bx) $display("note: %s ovf expectation undefined", tag);
`endif
    if (!hold) begin
      out_ready = 1'b1;
      tick();
      chk({tag, ".out_valid_one_cycle"}, 64'(out_valid), 64'd0);
      chk({tag, ".in_ready_post"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.sum", 64'(sum), 64'd0);
    chk("reset.cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset.ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("add_80_ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);

    // Backpressure: result must hold while a stray in_valid is ignored
    out_ready = 1'b0;
    run_op("bp_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      a        = 8'hFF;
      b        = 8'hFF;
      cin      = 1'b1;
      in_valid = 1'b1;
      tick();
      chk("bp.sum_hold", 64'(sum), 64'h46);
      chk("bp.cout_hold", 64'(cout), 64'd0);
      chk("bp.out_valid_hold", 64'(out_valid), 64'd1);
      chk("bp.in_ready_low", 64'(in_ready), 64'd0);
    end
    // in_valid stays high across the output handshake: it must not be taken there
    out_ready = 1'b1;
    tick();
    chk("bp.in_ready_after_hs", 64'(in_ready), 64'd1);
    chk("bp.out_valid_after_hs", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    chk("bp.sum_kept", 64'(sum), 64'h46);

    // Reset during RUN discards the operation
    a        = 8'h0F;
    b        = 8'h0F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rst.in_run", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.sum", 64'(sum), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready_release", 64'(in_ready), 64'd1);
    run_op("post_rst_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    // Back-to-back: second accept on the cycle after the first handshake
    run_op("b2b_aa_55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("b2b_00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that accepts two parallel operands and a carry-in through a valid/ready handshake. It adds them LSB-first, one bit per clock, using a single `full_adder` cell and a registered carry. It returns the parallel sum and carry-out through a second valid/ready handshake. It sits directly around the one-bit `full_adder` cell, feeding it bit pairs and consuming its sum/carry, so multi-bit addition costs one cell plus shift registers.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range 2..64.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: operands `a`, `b`, `cin` are valid.
- `in_ready` out 1: block can accept operands (IDLE only).
- `a` in WIDTH: operand A, unsigned or two's complement.
- `b` in WIDTH: operand B.
- `cin` in 1: carry-in.
- `out_valid` out 1: `sum`, `cout` (and `ovf`) are valid.
- `out_ready` in 1: consumer accepts the result.
- `sum` out WIDTH: a + b + cin, modulo 2^WIDTH.
- `cout` out 1: carry out of the MSB.
- `ovf` out 1: signed overflow; present only with `SERIAL_ADDER_OVF_EN`.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - RUN: one bit computed per cycle.
  - DONE: `out_valid=1`.
- IDLE → RUN on `in_valid && in_ready`:
  - load `a`, `b` into shift registers;
  - load carry register with `cin`;
  - clear bit counter and sum shift register.
- RUN, each cycle:
  - `full_adder` takes `a_sr[0]`, `b_sr[0]`, carry register;
  - its sum shifts into `sum_sr` MSB-side (right shift);
  - its carry updates the carry register;
  - `a_sr` and `b_sr` shift right;
  - counter increments.
- RUN → DONE on the cycle the counter reaches WIDTH-1; that bit is still processed.
- DONE → IDLE on `out_valid && out_ready`.
- `in_ready` is low in RUN and DONE. `in_valid` is ignored there, and input values are never sampled outside the IDLE handshake.
- `sum`, `cout` and `ovf` are driven from registers and are stable while `out_valid && !out_ready`.
- No accept is possible in the same cycle as the output handshake; `in_ready` rises the following cycle.
- Counter width is `$clog2(WIDTH)`; it saturates behaviour-free because the state leaves RUN.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `sum=0`, `cout=0`, `ovf=0`, all shift/carry/counter registers 0.
- Accept at edge E0. RUN spans E1..EWIDTH, and `out_valid` is high after edge EWIDTH. Latency is WIDTH cycles from accept edge to `out_valid`.
- With `out_ready` held high, `out_valid` is high for exactly one cycle.
- Throughput: one operation per WIDTH+2 cycles.
- Reset asserted mid-RUN or in DONE: immediate abort to reset values; the in-flight result is discarded.
- `cout` and `ovf` update together with `sum` on the final RUN edge, never earlier.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - port `ovf` exists;
  - `ovf` = carry into the MSB XOR carry out of the MSB, captured on the final RUN edge;
  - `ovf` is 1 iff a two's-complement overflow occurred.
- Undefined: `ovf` port and its register are absent; all other behaviour is identical.

## Structure
- Package `serial_adder_pkg`:
  - state enum `sa_state_t` {IDLE, RUN, DONE};
  - constant `SA_DEFAULT_WIDTH = 8`.
- One sub-module: the existing `full_adder` cell, instantiated once for the per-bit sum and carry; it is not reimplemented inline.

## Test plan
- 0x0F + 0x01, cin=0 (WIDTH=8) → `sum`=0x10, `cout`=0; `out_valid` rises exactly 8 cycles after the accept edge.
- 0xFF + 0x01, cin=0 → `sum`=0x00, `cout`=1. Also 0xFF + 0xFF, cin=1 → `sum`=0xFF, `cout`=1.
- With `SERIAL_ADDER_OVF_EN`:
  - 0x7F + 0x01 → `sum`=0x80, `ovf`=1;
  - 0x80 + 0xFF → `sum`=0x7F, `cout`=1, `ovf`=1;
  - 0x05 + 0x03 → `ovf`=0.
- Backpressure: 0x12 + 0x34, `out_ready` low for 5 cycles after `out_valid`:
  - `sum`=0x46 held stable;
  - `in_ready`=0;
  - a new `in_valid` in that window is ignored;
  - after the handshake, IDLE and `in_ready`=1 on the next cycle.
- Reset mid-operation: `rst_n` low at RUN bit 3 → `out_valid`=0 and `sum`=0 immediately; after release, `in_ready`=1, and 0x01 + 0x01 yields 0x02.
- Back-to-back: 0xAA + 0x55, cin=0 → 0xFF, `cout`=0, then 0x00 + 0x00, cin=1 → 0x01. The second accept occurs no earlier than the cycle after the first output handshake.
